// File: rtl/mux_share_arbiter_pkg.sv
// Shared definitions for the result-path arbiter: FSM state encoding,
// counter width and the default data width.
package mux_share_arbiter_pkg;

   localparam int DW_DEFAULT = 4;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

endpackage

// File: rtl/mux_share_arbiter_mux.sv
// Plain 2:1 data select for the shared result path (sel=0 -> a, sel=1 -> b).
module mux4b_2_to_1 #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin burst arbiter sharing one result path between ALU writeback
// (requester 0) and load return (requester 1), with a registered output stage.
module mux_share_arbiter
   import mux_share_arbiter_pkg::*;
#(
   parameter int DW        = DW_DEFAULT,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [DW-1:0] data0,
   input  logic          last0,
   input  logic          req1,
   input  logic [DW-1:0] data1,
   input  logic          last1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          ack0,
   output logic          ack1,
   output logic          sel,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   // Count value seen before the beat that hits the burst limit.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             ptr;
   logic             space;
   logic             ack_any;
   logic             owner_last;
   logic             release_beat;
   logic [DW-1:0]    mux_y;

   // NOTE: acks are combinational so a beat can be taken in the same cycle the
   // output stage frees up; they depend only on registered state plus inputs.
   assign space        = !out_valid || out_ready;
   assign ack0         = gnt0 & req0 & space;
   assign ack1         = gnt1 & req1 & space;
   assign ack_any      = ack0 | ack1;
   assign owner_last   = (gnt0 & last0) | (gnt1 & last1);
   assign release_beat = ack_any & (owner_last | (count == LAST_CNT));

   mux4b_2_to_1 #(
      .W (DW)
   ) u_mux (
      .a   (data0),
      .b   (data1),
      .sel (sel),
      .y   (mux_y)
   );

   // NOTE: every register here uses non-blocking assignment so all updates see
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         sel       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         count     <= '0;
         ptr       <= 1'b0;
      end else begin
         if (ack_any) begin
            out_data  <= mux_y;
            out_valid <= 1'b1;
            count     <= release_beat ? '0 : count + 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               // sel is left alone here so the mux keeps its last selection.
               if (req0 && (!req1 || !ptr)) begin
                  state <= OWN0;
                  gnt0  <= 1'b1;
                  sel   <= 1'b0;
               end else if (req1) begin
                  state <= OWN1;
                  gnt1  <= 1'b1;
                  sel   <= 1'b1;
               end
            end
            OWN0: begin
               if (release_beat) begin
                  ptr  <= 1'b1;
                  gnt0 <= 1'b0;
                  if (req1) begin
                     state <= OWN1;
                     gnt1  <= 1'b1;
                     sel   <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            OWN1: begin
               if (release_beat) begin
                  ptr  <= 1'b0;
                  gnt1 <= 1'b0;
                  if (req0) begin
                     state <= OWN0;
                     gnt0  <= 1'b1;
                     sel   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed vector table, corner-case
// sequences and random traffic against a requester-indexed reference model.
module tb_mux_share_arbiter;

   localparam int DW        = 4;
   localparam int MAX_BURST = 4;

   typedef struct packed {
      logic          rst;
      logic          req0;
      logic [DW-1:0] data0;
      logic          last0;
      logic          req1;
      logic [DW-1:0] data1;
      logic          last1;
      logic          ready;
   } in_t;

   typedef struct packed {
      logic          gnt0;
      logic          gnt1;
      logic          ack0;
      logic          ack1;
      logic          sel;
      logic          valid;
      logic [DW-1:0] data;
   } obs_t;

   typedef struct packed {
      in_t  in;
      obs_t exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst, req0, last0, req1, last1, out_ready;
   logic [DW-1:0] data0, data1;
   logic          gnt0, gnt1, ack0, ack1, sel, out_valid;
   logic [DW-1:0] out_data;

   int   total = 0;
   int   bad   = 0;
   obs_t last_obs;

   // Reference model: owner is -1 (nobody), 0 or 1; beats counts accepted beats.
   int            m_owner, m_ptr, m_beats;
   logic          m_sel, m_valid;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   mux_share_arbiter #(
      .DW        (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .data0     (data0),
      .last0     (last0),
      .req1      (req1),
      .data1     (data1),
      .last1     (last1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .ack0      (ack0),
      .ack1      (ack1),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   function automatic in_t mk_in(input logic r, input logic q0, input logic [DW-1:0] d0,
                                 input logic l0, input logic q1, input logic [DW-1:0] d1,
                                 input logic l1, input logic rdy);
      in_t v;
      v.rst = r;  v.req0 = q0; v.data0 = d0; v.last0 = l0;
      v.req1 = q1; v.data1 = d1; v.last1 = l1; v.ready = rdy;
      return v;
   endfunction

   function automatic obs_t mk_obs(input logic g0, input logic g1, input logic a0,
                                   input logic a1, input logic s, input logic v,
                                   input logic [DW-1:0] d);
      obs_t o;
      o.gnt0 = g0; o.gnt1 = g1; o.ack0 = a0; o.ack1 = a1;
      o.sel = s; o.valid = v; o.data = d;
      return o;
   endfunction

   function automatic obs_t model_obs(input in_t v);
      obs_t o;
      logic space;
      logic req [2];
      req[0] = v.req0;
      req[1] = v.req1;
      space  = !m_valid || v.ready;
      o.gnt0  = (m_owner == 0);
      o.gnt1  = (m_owner == 1);
      o.ack0  = (m_owner == 0) && req[0] && space;
      o.ack1  = (m_owner == 1) && req[1] && space;
      o.sel   = m_sel;
      o.valid = m_valid;
      o.data  = m_data;
      return o;
   endfunction

   task automatic model_step(input in_t v);
      obs_t          o;
      logic          accepted;
      int            other;
      logic          req [2];
      logic          lst [2];
      logic [DW-1:0] dat [2];
      if (v.rst) begin
         m_owner = -1; m_ptr = 0; m_beats = 0;
         m_sel = 1'b0; m_valid = 1'b0; m_data = '0;
         return;
      end
      req[0] = v.req0;  req[1] = v.req1;
      lst[0] = v.last0; lst[1] = v.last1;
      dat[0] = v.data0; dat[1] = v.data1;
      o = model_obs(v);
      accepted = o.ack0 || o.ack1;
      if (m_owner < 0) begin
         if (req[0] && req[1]) m_owner = m_ptr;
         else if (req[0])      m_owner = 0;
         else if (req[1])      m_owner = 1;
      end else if (accepted) begin
         m_data  = dat[m_owner];
         m_valid = 1'b1;
         m_beats = m_beats + 1;
         if (lst[m_owner] || m_beats == MAX_BURST) begin
            other   = 1 - m_owner;
            m_ptr   = other;
            m_beats = 0;
            m_owner = req[other] ? other : -1;
         end
      end
      if (!accepted && m_valid && v.ready) m_valid = 1'b0;
      if (m_owner >= 0) m_sel = (m_owner == 1);
   endtask

   task automatic check(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got g0=%b g1=%b a0=%b a1=%b sel=%b v=%b d=%h, want g0=%b g1=%b a0=%b a1=%b sel=%b v=%b d=%h",
                  name, act.gnt0, act.gnt1, act.ack0, act.ack1, act.sel, act.valid, act.data,
                  exp.gnt0, exp.gnt1, exp.ack0, exp.ack1, exp.sel, exp.valid, exp.data);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // mode 0: drive only, 1: compare with given expectation, 2: compare with model
   task automatic cycle(input in_t v, input int mode, input obs_t exp, input string name);
      obs_t e;
      rst = v.rst; req0 = v.req0; data0 = v.data0; last0 = v.last0;
      req1 = v.req1; data1 = v.data1; last1 = v.last1; out_ready = v.ready;
      #6;
      last_obs = '{gnt0, gnt1, ack0, ack1, sel, out_valid, out_data};
      e = (mode == 1) ? exp : model_obs(v);
      if (mode != 0) check(name, last_obs, e);
      @(posedge clk);
      model_step(v);
      #1;
   endtask

   task automatic mcycle(input in_t v, input string name);
      cycle(v, 2, '0, name);
   endtask

   task automatic do_reset();
      cycle(mk_in(1, 0, 0, 0, 0, 0, 0, 1), 0, '0, "reset");
   endtask

   vec_t vec [12];

   initial begin
      int b, acks_before_g0;
      bit seen_g0;
      in_t v;

      vec[0]  = '{mk_in(0, 1, 4'hA, 1, 0, 4'h0, 0, 1), mk_obs(0, 0, 0, 0, 0, 0, 4'h0)};
      vec[1]  = '{mk_in(0, 1, 4'hA, 1, 0, 4'h0, 0, 1), mk_obs(1, 0, 1, 0, 0, 0, 4'h0)};
      vec[2]  = '{mk_in(0, 0, 4'h0, 0, 0, 4'h0, 0, 1), mk_obs(0, 0, 0, 0, 0, 1, 4'hA)};
      vec[3]  = '{mk_in(0, 0, 4'h0, 0, 0, 4'h0, 0, 1), mk_obs(0, 0, 0, 0, 0, 0, 4'hA)};
      vec[4]  = '{mk_in(1, 0, 4'h0, 0, 0, 4'h0, 0, 1), mk_obs(0, 0, 0, 0, 0, 0, 4'hA)};
      vec[5]  = '{mk_in(0, 1, 4'h3, 1, 1, 4'hC, 1, 1), mk_obs(0, 0, 0, 0, 0, 0, 4'h0)};
      vec[6]  = '{mk_in(0, 1, 4'h3, 1, 1, 4'hC, 1, 1), mk_obs(1, 0, 1, 0, 0, 0, 4'h0)};
      vec[7]  = '{mk_in(0, 1, 4'h5, 1, 1, 4'h6, 1, 1), mk_obs(0, 1, 0, 1, 1, 1, 4'h3)};
      vec[8]  = '{mk_in(0, 1, 4'h9, 1, 1, 4'hE, 1, 1), mk_obs(1, 0, 1, 0, 0, 1, 4'h6)};
      vec[9]  = '{mk_in(0, 0, 4'h0, 0, 1, 4'hE, 1, 1), mk_obs(0, 1, 0, 1, 1, 1, 4'h9)};
      vec[10] = '{mk_in(0, 0, 4'h0, 0, 0, 4'h0, 0, 1), mk_obs(0, 0, 0, 0, 1, 1, 4'hE)};
      vec[11] = '{mk_in(0, 0, 4'h0, 0, 0, 4'h0, 0, 1), mk_obs(0, 0, 0, 0, 1, 0, 4'hE)};

      @(posedge clk);
      #1;
      do_reset();
      do_reset();
      check("reset_state", last_obs, mk_obs(0, 0, 0, 0, 0, 0, 4'h0));

      for (int i = 0; i < 12; i++)
         cycle(vec[i].in, 1, vec[i].exp, $sformatf("vec[%0d]", i));

      // Burst of 6 from requester 1 against MAX_BURST=4 while requester 0 waits.
      do_reset();
      mcycle(mk_in(0, 0, 0, 0, 1, 4'h1, 0, 1), "burst_grant");
      b = 0; acks_before_g0 = 0; seen_g0 = 0;
      for (int k = 0; k < 40 && b < 6; k++) begin
         v = mk_in(0, 1, 4'hF, 1, 1, 4'(b + 1), (b == 5), 1);
         mcycle(v, $sformatf("burst[%0d]", k));
         if (last_obs.gnt0) seen_g0 = 1;
         if (last_obs.ack1) begin
            b++;
            if (!seen_g0) acks_before_g0++;
         end
      end
      check_val("burst_beats_done", b, 6);
      check_val("burst_acks_before_release", acks_before_g0, MAX_BURST);

      // Backpressure on owner 0 with a held output beat.
      do_reset();
      mcycle(mk_in(0, 1, 4'h1, 0, 0, 0, 0, 1), "bp_grant");
      mcycle(mk_in(0, 1, 4'h1, 0, 0, 0, 0, 1), "bp_first");
      for (int k = 0; k < 3; k++) begin
         mcycle(mk_in(0, 1, 4'h2, 1, 0, 0, 0, 0), $sformatf("bp_stall[%0d]", k));
         check_val($sformatf("bp_stall_ack[%0d]", k), int'(last_obs.ack0), 0);
         check_val($sformatf("bp_stall_data[%0d]", k), int'(last_obs.data), 1);
      end
      mcycle(mk_in(0, 1, 4'h2, 1, 0, 0, 0, 1), "bp_release");
      check_val("bp_accept_ack", int'(last_obs.ack0), 1);
      mcycle(mk_in(0, 0, 0, 0, 0, 0, 0, 1), "bp_after");
      check_val("bp_after_data", int'(last_obs.data), 2);

      // Owner 1 drops its request mid-burst; grant must hold.
      do_reset();
      mcycle(mk_in(0, 0, 0, 0, 1, 4'h7, 0, 1), "drop_grant");
      mcycle(mk_in(0, 0, 0, 0, 1, 4'h7, 0, 1), "drop_beat");
      for (int k = 0; k < 2; k++) begin
         mcycle(mk_in(0, 1, 4'h4, 1, 0, 0, 0, 1), $sformatf("drop_gap[%0d]", k));
         check_val($sformatf("drop_gap_gnt1[%0d]", k), int'(last_obs.gnt1), 1);
         check_val($sformatf("drop_gap_gnt0[%0d]", k), int'(last_obs.gnt0), 0);
      end
      mcycle(mk_in(0, 1, 4'h4, 1, 1, 4'h8, 1, 1), "drop_last");
      check_val("drop_last_ack1", int'(last_obs.ack1), 1);
      mcycle(mk_in(0, 1, 4'h4, 1, 0, 0, 0, 1), "drop_handoff");
      check_val("drop_handoff_gnt0", int'(last_obs.gnt0), 1);

      // Reset while owner 1 holds the path with a pending output beat.
      do_reset();
      mcycle(mk_in(0, 0, 0, 0, 1, 4'h5, 0, 1), "rst_grant");
      mcycle(mk_in(0, 0, 0, 0, 1, 4'h5, 0, 1), "rst_beat");
      cycle(mk_in(1, 0, 0, 0, 1, 4'h5, 0, 0), 2, '0, "rst_assert");
      mcycle(mk_in(0, 1, 4'h6, 1, 1, 4'h9, 1, 1), "rst_after");
      check("rst_after_state", last_obs, mk_obs(0, 0, 0, 0, 0, 0, 4'h0));
      mcycle(mk_in(0, 1, 4'h6, 1, 1, 4'h9, 1, 1), "rst_favour0");
      check_val("rst_favour0_gnt0", int'(last_obs.gnt0), 1);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         v = mk_in($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 4'($urandom),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, 4'($urandom),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
         mcycle(v, $sformatf("rand[%0d]", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
Round-robin arbiter that shares one 4-bit result path between two requesters (ALU writeback and load return) in the RISC datapath. It owns the select of the 4-bit 2:1 mux, grants the path for bursts, and registers the selected data into a valid/ready output stage toward the register-file write port.

Parameters:
DW, 4, data width through the shared path.
MAX_BURST, 4, maximum accepted beats per grant before forced release (range 1..15).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 has a beat on data0
data0  input  DW  requester 0 beat
last0  input  1  requester 0 beat is end of burst
req1  input  1  requester 1 has a beat on data1
data1  input  DW  requester 1 beat
last1  input  1  requester 1 beat is end of burst
gnt0  output  1  registered; requester 0 owns path
gnt1  output  1  registered; requester 1 owns path
ack0  output  1  combinational; requester 0 beat accepted this cycle
ack1  output  1  combinational; requester 1 beat accepted this cycle
sel  output  1  mux select (0=data0, 1=data1), registered
out_data  output  DW  registered shared-path data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0, out_data=0, beat count=0, priority pointer=0 (requester 0 favoured first). Reset mid-burst drops the grant and any pending out_data without completion.
- States: IDLE, OWN0, OWN1. gntN=1 exactly in OWNN; sel=1 only in OWN1, held in IDLE.
- IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> OWN(pointer); none -> stay. No ack in IDLE.
- space = !out_valid | out_ready. ackN = gntN & reqN & space.
- On ackN: out_data <= mux(sel) output, out_valid <= 1, beat count +1.
- If no ack and out_valid & out_ready: out_valid <= 0, out_data unchanged.
- Release in OWNN on the accepting beat when lastN=1 or beat count reaches MAX_BURST (count = MAX_BURST-1 before the beat). Release sets pointer <= other, count <= 0. Next state is OWN(other) if req(other)=1 that cycle, else IDLE. Handoff costs no idle cycle.
- Owner holding grant with reqN=0: no release, no timeout; grant held until a last/limit beat.
- Latency: req in IDLE at cycle t -> gnt at t+1; ack possible at t+1; out_valid at t+2. Sustained throughput is one beat/cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 -> ack=0, out_data stable, state and count unchanged.
- gnt0 & gnt1 never both 1; ack0 & ack1 never both 1.
- Count width: 4 bits.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the DW default.
- Sub-module: instantiate the existing 4-bit 2:1 mux mux4b_2_to_1 for the data select, with sel from the FSM. The FSM, counter, pointer and output register stay in this module.

Test Plan:
- Reset then req0=1, data0=4'hA, last0=1, out_ready=1 -> gnt0 at cycle 1, ack0 at cycle 1, out_data=4'hA with out_valid=1 at cycle 2, state IDLE, pointer=1.
- req0=req1=1 from reset, all beats last=1 -> grants alternate 0,1,0,1 with back-to-back handoff (no IDLE cycle); out_data follows data0/data1 alternately.
- req1 burst of 6 beats (last only on beat 6), MAX_BURST=4, req0=1 -> forced release after 4th ack1; gnt0 next cycle; gnt1 regained later for the remaining 2 beats.
- Owner 0 granted, out_ready=0 for 3 cycles with out_valid=1 -> ack0=0, out_data stable for 3 cycles; the beat is accepted on the first cycle out_ready=1.
- Owner 1 mid-burst drops req1 for 2 cycles, req0=1 -> gnt1 held, no acks, gnt0 stays 0 until req1 returns with last1=1.
- Assert rst during OWN1 with out_valid=1 -> next cycle gnt0=gnt1=0, out_valid=0, sel=0; next arbitration favours requester 0.
